// File: rtl/axis_pkt_mux_pkg.sv
// axis_pkt_mux_pkg: shared constants, FSM state type and helpers for the packet mux
package axis_pkt_mux_pkg;
  localparam int SEL_EN_BIT = 7;
  localparam int SEL_IDX_W = 7;
  localparam logic [7:0] NON_CHAN_SEL = 8'd0;
  typedef enum logic {IDLE, LOCK} state_e;
  function automatic logic [SEL_IDX_W-1:0] wrap_inc(input logic [SEL_IDX_W-1:0] c, input int n);
    return (int'(c) == n - 1) ? '0 : c + 1'b1;
  endfunction
endpackage

// File: rtl/axis_pkt_mux_if.sv
// axis_pkt_mux_if: N-lane AXI-Stream bundle; N=N_CH on the input side, N=1 on the output side
interface axis_pkt_mux_if #(parameter int N = 1, parameter int DW = 32);
  logic [N-1:0] tvalid;
  logic [N-1:0] tready;
  logic [N-1:0] tlast;
  logic [N*DW-1:0] tdata;
  logic [N*DW/8-1:0] tkeep;
  modport master(output tvalid, tdata, tkeep, tlast, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_mux_reg_slice.sv
// axis_reg_slice: 2-entry skid output register; upstream ready comes only from registered state
module axis_reg_slice #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_keep,
  input  logic            i_last,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_keep,
  output logic            o_last
);
  localparam int W = DW + DW / 8 + 1;
  logic [W-1:0] r_main, r_skid;
  logic r_main_v, r_skid_v;
  logic w_in_fire, w_load;
  assign o_ready = !r_skid_v;
  assign w_in_fire = i_valid & !r_skid_v;
  assign w_load = !r_main_v | i_ready;
  assign o_valid = r_main_v;
  assign {o_last, o_keep, o_data} = r_main;
  // main refills from the skid (older beat) first; skid only catches a beat while main is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_main_v <= 1'b0;
      r_skid <= '0;
      r_skid_v <= 1'b0;
    end else if (w_load) begin
      if (r_skid_v | w_in_fire) r_main <= r_skid_v ? r_skid : {i_last, i_keep, i_data};
      r_main_v <= r_skid_v | w_in_fire;
      r_skid_v <= 1'b0;
    end else if (w_in_fire) begin
      r_skid <= {i_last, i_keep, i_data};
      r_skid_v <= 1'b1;
    end
  end
endmodule

// File: rtl/axis_pkt_mux.sv
// axis_pkt_mux: N:1 AXI-Stream packet mux with packet-locked grant and registered output slice
module axis_pkt_mux
  import axis_pkt_mux_pkg::*;
#(
  parameter int N_CH = 10,
  parameter int DW = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           bus_sel,
  axis_pkt_mux_if.slave        s_axis,
  axis_pkt_mux_if.master       m_axis,
  output logic [SEL_IDX_W-1:0] cur_chan,
  output logic                 busy
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  state_e r_state, w_state_nxt;
  logic [SEL_IDX_W-1:0] r_chan, w_chan_nxt, r_rr_ptr, w_rr_idx, w_grant_idx;
  logic [CW-1:0] w_ci;
  logic [2*N_CH-1:0] w_dbl;
  logic w_rr_ok, w_sel_ok, w_grant_ok;
  logic w_in_valid, w_slice_rdy, w_accept, w_last;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_keep;
  logic w_m_valid, w_m_last;
  logic [DW-1:0] w_m_data;
  logic [DW/8-1:0] w_m_keep;
  assign w_ci = r_chan[CW-1:0];
  assign w_data = s_axis.tdata[w_ci*DW +: DW];
  assign w_keep = s_axis.tkeep[w_ci*(DW/8) +: DW/8];
  assign w_last = s_axis.tlast[w_ci];
  assign w_in_valid = (r_state == LOCK) & s_axis.tvalid[w_ci];
  assign w_accept = w_in_valid & w_slice_rdy;
  assign s_axis.tready = (r_state == LOCK && w_slice_rdy) ? (N_CH'(1) << w_ci) : '0;
  assign w_sel_ok = bus_sel[SEL_EN_BIT] && (int'(bus_sel[SEL_IDX_W-1:0]) < N_CH);
  assign w_grant_ok = (ARB_MODE == 1) ? w_rr_ok : w_sel_ok;
  assign w_grant_idx = (ARB_MODE == 1) ? w_rr_idx : bus_sel[SEL_IDX_W-1:0];
  assign w_dbl = {s_axis.tvalid, s_axis.tvalid} >> r_rr_ptr;
  assign cur_chan = (r_state == LOCK) ? r_chan : '0;
  assign busy = (r_state == LOCK);
  // round-robin: lowest valid channel at/after the pointer; descending scan lets the nearest win
  always_comb begin
    w_rr_ok = 1'b0;
    w_rr_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_dbl[k]) begin
        w_rr_ok = 1'b1;
        w_rr_idx = (int'(r_rr_ptr) + k >= N_CH) ? SEL_IDX_W'(int'(r_rr_ptr) + k - N_CH) : SEL_IDX_W'(int'(r_rr_ptr) + k);
      end
    end
  end
  // grant FSM next state: take a grant from IDLE, release on the accepted tlast beat
  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt = r_chan;
    if (r_state == IDLE && w_grant_ok) begin
      w_state_nxt = LOCK;
      w_chan_nxt = w_grant_idx;
    end else if (w_accept && w_last) begin
      w_state_nxt = IDLE;
    end
  end
  // state, granted channel and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_chan <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan <= w_chan_nxt;
      if (w_accept && w_last) r_rr_ptr <= wrap_inc(r_chan, N_CH);
    end
  end
  axis_reg_slice #(.DW(DW)) u_slice (
    .clk(clk),
    .rst(rst),
    .i_valid(w_in_valid),
    .o_ready(w_slice_rdy),
    .i_data(w_data),
    .i_keep(w_keep),
    .i_last(w_last),
    .o_valid(w_m_valid),
    .i_ready(m_axis.tready[0]),
    .o_data(w_m_data),
    .o_keep(w_m_keep),
    .o_last(w_m_last)
  );
  assign m_axis.tvalid = w_m_valid;
  assign m_axis.tdata = w_m_data;
  assign m_axis.tkeep = w_m_keep;
  assign m_axis.tlast = w_m_last;
endmodule

// File: tb/tb_axis_pkt_mux.sv
// tb_axis_pkt_mux: directed checks of select, lock, stall, round-robin and reset behaviour
module tb_axis_pkt_mux;
  localparam int N = 10;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_ready = 1'b0;
  logic use1 = 1'b0;
  logic [7:0] bus_sel = 8'h00;
  logic [6:0] cur0, cur1;
  logic busy0, busy1;
  int n_tests = 0;
  int n_fail = 0;
  int pos[N];
  int len[N];
  int plen[N];
  logic [31:0] base[N];
  logic en[N];
  logic [36:0] q[$];
  axis_pkt_mux_if #(.N(N), .DW(DW)) s0();
  axis_pkt_mux_if #(.N(N), .DW(DW)) s1();
  axis_pkt_mux_if #(.N(1), .DW(DW)) m0();
  axis_pkt_mux_if #(.N(1), .DW(DW)) m1();
  axis_pkt_mux #(.N_CH(N), .DW(DW), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .s_axis(s0), .m_axis(m0), .cur_chan(cur0), .busy(busy0)
  );
  axis_pkt_mux #(.N_CH(N), .DW(DW), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .s_axis(s1), .m_axis(m1), .cur_chan(cur1), .busy(busy1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = en[i] && pos[i] < len[i];
      s0.tvalid[i] = v && !use1;
      s1.tvalid[i] = v && use1;
      s0.tdata[i*DW +: DW] = base[i] + 32'(pos[i]);
      s1.tdata[i*DW +: DW] = base[i] + 32'(pos[i]);
      s0.tkeep[i*KW +: KW] = 4'(pos[i] + 1);
      s1.tkeep[i*KW +: KW] = 4'(pos[i] + 1);
      s0.tlast[i] = (pos[i] % plen[i]) == plen[i] - 1;
      s1.tlast[i] = (pos[i] % plen[i]) == plen[i] - 1;
    end
    m0.tready = m_ready;
    m1.tready = m_ready;
  endtask
  task automatic cyc();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = use1 ? (s1.tvalid & s1.tready) : (s0.tvalid & s0.tready);
    if (use1 ? (m1.tvalid[0] & m_ready) : (m0.tvalid[0] & m_ready))
      q.push_back(use1 ? {m1.tlast[0], m1.tkeep, m1.tdata} : {m0.tlast[0], m0.tkeep, m0.tdata});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
    drive();
  endtask
  task automatic set_src(input int ch, input logic [31:0] b, input int l, input int p);
    base[ch] = b;
    len[ch] = l;
    plen[ch] = p;
    pos[ch] = 0;
    en[ch] = 1'b1;
  endtask
  task automatic clr_src();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0;
      pos[i] = 0;
      len[i] = 0;
      plen[i] = 1;
      base[i] = '0;
    end
  endtask
  task automatic run_until(input string tag, input int ch, input int n);
    for (int t = 0; t < 40 && pos[ch] < n; t++) cyc();
    chk(tag, 64'(pos[ch]), 64'(n));
  endtask
  initial begin
    logic [31:0] e5_d[8];
    logic [3:0] e5_k[8];
    e5_d = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h900, 32'h901, 32'h102, 32'h103};
    e5_k = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4};
    clr_src();
    drive();
    cyc();
    cyc();
    chk("rst_mvalid", 64'(m0.tvalid), 0);
    chk("rst_mdata", 64'(m0.tdata), 0);
    chk("rst_mkeep", 64'(m0.tkeep), 0);
    chk("rst_mlast", 64'(m0.tlast), 0);
    chk("rst_sready", 64'(s0.tready), 0);
    chk("rst_cur", 64'(cur0), 0);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_mvalid1", 64'(m1.tvalid), 0);
    rst = 1'b0;
    bus_sel = 8'h83;
    m_ready = 1'b1;
    set_src(3, 32'hA0, 4, 4);
    drive();
    cyc();
    chk("t1_busy_g", 64'(busy0), 1);
    chk("t1_cur_g", 64'(cur0), 3);
    chk("t1_sready_g", 64'(s0.tready), 64'h008);
    chk("t1_mvalid_g", 64'(m0.tvalid), 0);
    cyc();
    chk("t1_b0", {m0.tvalid, m0.tlast, m0.tkeep, m0.tdata}, {1'b1, 1'b0, 4'h1, 32'hA0});
    chk("t1_busy_b0", 64'(busy0), 1);
    cyc();
    chk("t1_b1", {m0.tvalid, m0.tlast, m0.tkeep, m0.tdata}, {1'b1, 1'b0, 4'h2, 32'hA1});
    cyc();
    chk("t1_b2", {m0.tvalid, m0.tlast, m0.tkeep, m0.tdata}, {1'b1, 1'b0, 4'h3, 32'hA2});
    chk("t1_busy_b2", 64'(busy0), 1);
    bus_sel = 8'h00;
    cyc();
    chk("t1_b3", {m0.tvalid, m0.tlast, m0.tkeep, m0.tdata}, {1'b1, 1'b1, 4'h4, 32'hA3});
    chk("t1_busy_end", 64'(busy0), 0);
    chk("t1_cur_end", 64'(cur0), 0);
    cyc();
    chk("t1_mvalid_end", 64'(m0.tvalid), 0);
    clr_src();
    q.delete();
    bus_sel = 8'h83;
    set_src(3, 32'hB0, 4, 4);
    set_src(5, 32'hC0, 2, 2);
    drive();
    run_until("t2_wait_b1", 3, 2);
    bus_sel = 8'h85;
    run_until("t2_wait_ch5", 5, 2);
    chk("t2_ch3_done", 64'(pos[3]), 4);
    bus_sel = 8'h00;
    repeat (3) cyc();
    chk("t2_qsize", 64'(q.size()), 6);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_b%0d", k), 64'(q[k]), {27'd0, k == 3, 4'(k + 1), 32'hB0 + 32'(k)});
    chk("t2_c0", 64'(q[4]), {27'd0, 1'b0, 4'h1, 32'hC0});
    chk("t2_c1", 64'(q[5]), {27'd0, 1'b1, 4'h2, 32'hC1});
    clr_src();
    q.delete();
    set_src(3, 32'hD0, 2, 2);
    bus_sel = 8'h03;
    drive();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t3_dis_sready", 64'(s0.tready), 0);
      chk("t3_dis_mvalid", 64'(m0.tvalid), 0);
    end
    bus_sel = 8'h8A;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t3_oor_sready", 64'(s0.tready), 0);
      chk("t3_oor_mvalid", 64'(m0.tvalid), 0);
      chk("t3_oor_busy", 64'(busy0), 0);
    end
    chk("t3_no_accept", 64'(pos[3]), 0);
    bus_sel = 8'h00;
    clr_src();
    q.delete();
    set_src(1, 32'hE0, 8, 8);
    bus_sel = 8'h81;
    drive();
    run_until("t4_wait_b1", 1, 2);
    m_ready = 1'b0;
    drive();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t4_stall_data", {m0.tvalid, m0.tlast, m0.tkeep, m0.tdata}, {1'b1, 1'b0, 4'h2, 32'hE1});
      chk("t4_stall_sready", 64'(s0.tready), 0);
      chk("t4_stall_busy", 64'(busy0), 1);
    end
    chk("t4_buffered", 64'(pos[1]), 3);
    m_ready = 1'b1;
    drive();
    run_until("t4_wait_end", 1, 8);
    bus_sel = 8'h00;
    repeat (3) cyc();
    chk("t4_qsize", 64'(q.size()), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t4_b%0d", k), 64'(q[k]), {27'd0, k == 7, 4'(k + 1), 32'hE0 + 32'(k)});
    clr_src();
    set_src(2, 32'hF0, 4, 4);
    bus_sel = 8'h82;
    drive();
    run_until("t6_wait_b0", 2, 1);
    rst = 1'b1;
    cyc();
    chk("t6_mvalid", 64'(m0.tvalid), 0);
    chk("t6_mdata", 64'(m0.tdata), 0);
    chk("t6_mkeep", 64'(m0.tkeep), 0);
    chk("t6_mlast", 64'(m0.tlast), 0);
    chk("t6_sready", 64'(s0.tready), 0);
    chk("t6_busy", 64'(busy0), 0);
    chk("t6_cur", 64'(cur0), 0);
    rst = 1'b0;
    q.delete();
    set_src(2, 32'h90, 2, 2);
    drive();
    run_until("t6_wait_fresh", 2, 2);
    bus_sel = 8'h00;
    repeat (3) cyc();
    chk("t6_qsize", 64'(q.size()), 2);
    chk("t6_f0", 64'(q[0]), {27'd0, 1'b0, 4'h1, 32'h90});
    chk("t6_f1", 64'(q[1]), {27'd0, 1'b1, 4'h2, 32'h91});
    clr_src();
    use1 = 1'b1;
    q.delete();
    set_src(0, 32'h100, 4, 2);
    set_src(2, 32'h200, 2, 2);
    set_src(9, 32'h900, 2, 2);
    drive();
    for (int t = 0; t < 60 && !(pos[0] == 4 && pos[2] == 2 && pos[9] == 2); t++) cyc();
    chk("t5_all_sent", {32'(pos[0]), 16'(pos[2]), 16'(pos[9])}, {32'd4, 16'd2, 16'd2});
    repeat (3) cyc();
    chk("t5_qsize", 64'(q.size()), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t5_b%0d", k), 64'(q[k]), {27'd0, k % 2 == 1, e5_k[k], e5_d[k]});
    chk("t5_idle", 64'(busy1), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
